ami_mem_responder: RTL



---
 rtl/ami_mem_if.sv | 70 +++++++
 rtl/ami_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : ami_mem_if
//  Description : AMI-style two-port memory bus between a requester (master)
//                and the backing-store responder (slave). Port 0 carries
//                reads, port 1 carries writes; each has a request channel
//                (valid/grant) and a response channel (valid/grant).
//                  rd_req_*  : read request  (addr, valid -> grant)
//                  wr_req_*  : write request (addr, data, valid -> grant)
//                  rd_resp_* : read response (data, valid -> grant = pop)
//                  wr_resp_* : write ack     (valid -> grant = pop)
//  Revision    : 1.0  initial release
// ============================================================================
interface ami_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    // Read request channel
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_req_grant;

    // Write request channel
    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic              wr_req_grant;

    // Read response channel
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_resp_data;
    logic              rd_resp_grant;

    // Write acknowledge channel
    logic              wr_resp_valid;
    logic              wr_resp_grant;

    // Requester / response consumer side
    modport master (
        output rd_req_valid,
        output rd_req_addr,
        input  rd_req_grant,
        output wr_req_valid,
        output wr_req_addr,
        output wr_req_data,
        input  wr_req_grant,
        input  rd_resp_valid,
        input  rd_resp_data,
        output rd_resp_grant,
        input  wr_resp_valid,
        output wr_resp_grant
    );

    // Memory responder side
    modport slave (
        input  rd_req_valid,
        input  rd_req_addr,
        output rd_req_grant,
        input  wr_req_valid,
        input  wr_req_addr,
        input  wr_req_data,
        output wr_req_grant,
        output rd_resp_valid,
        output rd_resp_data,
        input  rd_resp_grant,
        output wr_resp_valid,
        input  wr_resp_grant
    );
endinterface
`default_nettype wire

// File: rtl/ami_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ami_mem_responder
//  Description : Backing-store memory model servicing an accelerator's two
//                AMI-style ports (port 0 reads, port 1 writes). A single-
//                ported word RAM is shared by both ports; at most one access
//                is granted per cycle with alternating priority under
//                contention. Reads travel through a fixed RD_LAT-stage pipe
//                into a FWFT response queue; writes produce an ack in a small
//                FWFT ack queue. Both request grants are credit-guarded so
//                neither queue can overflow.
//
//  Ports       : clk, rst        clock, synchronous active-high reset
//                bus (slave)     read/write request and response channels
//                rd_count        accepted reads  (wraps mod 2^32)
//                wr_count        accepted writes (wraps mod 2^32)
//                busy            read in flight, queue non-empty or write
//                                being accepted
//
//  Revision    : 1.0  initial release
// ============================================================================
module ami_mem_responder #(
    parameter int ADDR_W   = 32,  // request byte-address width
    parameter int DATA_W   = 64,  // word width, power of two, >= 8
    parameter int MEM_LOG2 = 10,  // log2 of stored words
    parameter int RD_LAT   = 4,   // acceptance -> read-queue enqueue, 1..8
    parameter int RQ_LOG2  = 3,   // log2 of read response queue depth
    parameter int WQ_LOG2  = 2    // log2 of write ack queue depth
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ami_mem_if.slave   bus,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic        busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_B         = $clog2(DATA_W / 8);  // byte-offset bits
    localparam int c_MEM_WORDS = 2 ** MEM_LOG2;
    localparam int c_RQ_DEPTH  = 2 ** RQ_LOG2;
    localparam int c_WQ_DEPTH  = 2 ** WQ_LOG2;
    localparam int c_RQ_CW     = RQ_LOG2 + 1;          // read queue count width
    localparam int c_WQ_CW     = WQ_LOG2 + 1;          // ack queue count width
    localparam int c_CR_W      = RQ_LOG2 + 5;          // credit sum width

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0]   r_mem [0:c_MEM_WORDS-1];

    logic [MEM_LOG2-1:0] w_rd_idx;
    logic [MEM_LOG2-1:0] w_wr_idx;
    logic                w_unused_addr;

    logic                w_rd_elig;
    logic                w_wr_elig;
    logic                w_rd_grant;
    logic                w_wr_grant;
    logic                w_contend;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                r_last_wr;      // 1: write won the last contention

    logic [RD_LAT-1:0]   r_pipe_v;
    logic [DATA_W-1:0]   r_pipe_d [0:RD_LAT-1];
    logic [3:0]          r_inflight;     // RD_LAT <= 8 fits in 4 bits
    logic [c_CR_W-1:0]   w_credit_used;

    logic [DATA_W-1:0]   r_rq_mem [0:c_RQ_DEPTH-1];
    logic [RQ_LOG2-1:0]  r_rq_wptr;
    logic [RQ_LOG2-1:0]  r_rq_rptr;
    logic [c_RQ_CW-1:0]  r_rq_count;
    logic                w_rq_push;
    logic                w_rq_pop;
    logic                w_rq_nonempty;

    logic [c_WQ_CW-1:0]  r_wq_count;
    logic                w_wq_pop;
    logic                w_wq_nonempty;

    logic [31:0]         r_rd_count;
    logic [31:0]         r_wr_count;

    // ------------------------------------------------------------------------
    // Address decode: drop the byte offset and everything above the stored
    // range, so out-of-range addresses alias back into the RAM.
    // ------------------------------------------------------------------------
    assign w_rd_idx = bus.rd_req_addr[MEM_LOG2+c_B-1 -: MEM_LOG2];
    assign w_wr_idx = bus.wr_req_addr[MEM_LOG2+c_B-1 -: MEM_LOG2];

    // The ignored address bits are intentionally dropped.
    assign w_unused_addr = ^{bus.rd_req_addr, bus.wr_req_addr};

    // ------------------------------------------------------------------------
    // Eligibility
    //   Read credit: every accepted read holds a credit until its response is
    //   popped (not merely enqueued), so pipe + queue can never exceed the
    //   queue depth.
    //   Write ack: the ack is enqueued at the acceptance edge, so the ack
    //   queue occupancy alone decides whether another ack fits.
    // ------------------------------------------------------------------------
    assign w_credit_used = c_CR_W'(r_inflight) + c_CR_W'(r_rq_count);

    assign w_rd_elig = bus.rd_req_valid && (w_credit_used < c_CR_W'(c_RQ_DEPTH));
    assign w_wr_elig = bus.wr_req_valid && (r_wq_count < c_WQ_CW'(c_WQ_DEPTH));

    // ------------------------------------------------------------------------
    // Arbitration: one RAM access per cycle; under contention the side that
    // did not win the previous contention wins this one. No grants while rst.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_grant = 1'b0;
        w_wr_grant = 1'b0;
        if (!rst) begin
            if (w_rd_elig && w_wr_elig) begin
                w_rd_grant = r_last_wr;
                w_wr_grant = !r_last_wr;
            end else begin
                w_rd_grant = w_rd_elig;
                w_wr_grant = w_wr_elig;
            end
        end
    end

    assign w_contend = w_rd_elig && w_wr_elig && !rst;

    // Grants are only raised while valid is high, so grant == acceptance.
    assign w_rd_acc = w_rd_grant;
    assign w_wr_acc = w_wr_grant;

    assign bus.rd_req_grant = w_rd_grant;
    assign bus.wr_req_grant = w_wr_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_wr <= 1'b1;          // first contention goes to the read
        end else if (w_contend) begin
            r_last_wr <= w_wr_grant;
        end
    end

    // ------------------------------------------------------------------------
    // Word RAM and read data pipe (contents survive reset).
    // The RAM is read in the acceptance cycle into pipe stage 0; the last
    // stage is the enqueue into the read response queue, RD_LAT cycles after
    // acceptance.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_idx] <= bus.wr_req_data;
        end
        r_pipe_d[0] <= r_mem[w_rd_idx];
        for (int k = 1; k < RD_LAT; k++) begin
            r_pipe_d[k] <= r_pipe_d[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_v <= '0;
        end else begin
            r_pipe_v[0] <= w_rd_acc;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe_v[k] <= r_pipe_v[k-1];
            end
        end
    end

    assign w_rq_push = r_pipe_v[RD_LAT-1];

    // Number of reads currently in the pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= 4'd0;
        end else if (w_rd_acc && !w_rq_push) begin
            r_inflight <= r_inflight + 4'd1;
        end else if (!w_rd_acc && w_rq_push) begin
            r_inflight <= r_inflight - 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Read response queue (FWFT)
    // ------------------------------------------------------------------------
    assign w_rq_nonempty = (r_rq_count != '0);
    assign w_rq_pop      = bus.rd_resp_grant && w_rq_nonempty;

    always_ff @(posedge clk) begin
        if (w_rq_push) begin
            r_rq_mem[r_rq_wptr] <= r_pipe_d[RD_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rq_wptr  <= '0;
            r_rq_rptr  <= '0;
            r_rq_count <= '0;
        end else begin
            if (w_rq_push) begin
                r_rq_wptr <= r_rq_wptr + RQ_LOG2'(1);
            end
            if (w_rq_pop) begin
                r_rq_rptr <= r_rq_rptr + RQ_LOG2'(1);
            end
            if (w_rq_push && !w_rq_pop) begin
                r_rq_count <= r_rq_count + c_RQ_CW'(1);
            end else if (!w_rq_push && w_rq_pop) begin
                r_rq_count <= r_rq_count - c_RQ_CW'(1);
            end
        end
    end

    assign bus.rd_resp_valid = w_rq_nonempty;
    // Data is forced to zero while empty so stale entries never leak out.
    assign bus.rd_resp_data  = w_rq_nonempty ? r_rq_mem[r_rq_rptr] : '0;

    // ------------------------------------------------------------------------
    // Write ack queue: acks carry no payload, so only occupancy is kept.
    // ------------------------------------------------------------------------
    assign w_wq_nonempty = (r_wq_count != '0);
    assign w_wq_pop      = bus.wr_resp_grant && w_wq_nonempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wq_count <= '0;
        end else if (w_wr_acc && !w_wq_pop) begin
            r_wq_count <= r_wq_count + c_WQ_CW'(1);
        end else if (!w_wr_acc && w_wq_pop) begin
            r_wq_count <= r_wq_count - c_WQ_CW'(1);
        end
    end

    assign bus.wr_resp_valid = w_wq_nonempty;

    // ------------------------------------------------------------------------
    // Acceptance counters and activity flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
        end else begin
            if (w_rd_acc) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr_acc) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

    // A write being accepted counts as a scheduled ack.
    assign busy = (r_inflight != 4'd0) | w_rq_nonempty | w_wq_nonempty | w_wr_acc;

endmodule
`default_nettype wire
